// File: rtl/uart_reg_bridge_pkg.sv
// Shared definitions for the UART register bridge: FSM state encoding,
// response bytes, default command codes and the frame checksum helper.
package uart_bridge_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_CHK       = 3'd3;
    localparam logic [2:0] ST_EXEC      = 3'd4;
    localparam logic [2:0] ST_RDATA     = 3'd5;
    localparam logic [2:0] ST_RESP      = 3'd6;
    localparam logic [2:0] ST_RESP_WAIT = 3'd7;

    localparam logic [7:0] RESP_OK     = 8'h4B;
    localparam logic [7:0] RESP_BADCMD = 8'h3F;
    localparam logic [7:0] RESP_BADCHK = 8'h21;

    localparam logic [7:0] DEF_CMD_WR = 8'h57;
    localparam logic [7:0] DEF_CMD_RD = 8'h52;

    // Running frame checksum: XOR of every byte seen so far in the frame.
    function automatic logic [7:0] chk_accum(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_reg_bridge_timeout.sv
// Inter-byte timeout counter for the register bridge: cleared by the FSM,
// counts while enabled and flags expiry at LIMIT-1 (LIMIT of 0 never expires).
module bridge_timeout #(
    parameter logic [15:0] LIMIT = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [15:0] count_r;

    assign expire = enable && (LIMIT != 16'd0) && (count_r == (LIMIT - 16'd1));

    // Count idle cycles between bytes; hold once expired until the FSM clears us.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= 16'd0;
        end else if (clear) begin
            count_r <= 16'd0;
        end else if (enable && !expire) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// Binary register-access responder behind a UART (W addr data / R addr).
// Define UART_REG_BRIDGE_CHKSUM_EN to require a trailing XOR checksum byte.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  CMD_WR         = DEF_CMD_WR,
    parameter logic [7:0]  CMD_RD         = DEF_CMD_RD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       frame_err
);

    logic [2:0] state_r;
    logic       is_wr_r;
    logic [7:0] resp_r;
    logic       timed_s;
    logic       tmo_clear_s;
    logic       tmo_expire_s;
`ifdef UART_REG_BRIDGE_CHKSUM_EN
    logic [7:0] chk_r;
`endif

`ifdef UART_REG_BRIDGE_CHKSUM_EN
    assign timed_s = (state_r == ST_ADDR) || (state_r == ST_DATA) || (state_r == ST_CHK);
`else
    assign timed_s = (state_r == ST_ADDR) || (state_r == ST_DATA);
`endif
    assign tmo_clear_s = !timed_s || new_rx_data;

    bridge_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmo_clear_s),
        .enable (timed_s),
        .expire (tmo_expire_s)
    );

    // Frame decoder, bus sequencer and response handshake. Bus strobes are
    // launched on the edge into EXEC so they are high for the EXEC cycle only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            is_wr_r     <= 1'b0;
            resp_r      <= 8'h00;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            reg_addr    <= 8'h00;
            reg_wdata   <= 8'h00;
            reg_wr      <= 1'b0;
            reg_rd      <= 1'b0;
            frame_err   <= 1'b0;
`ifdef UART_REG_BRIDGE_CHKSUM_EN
            chk_r       <= 8'h00;
`endif
        end else begin
            reg_wr      <= 1'b0;
            reg_rd      <= 1'b0;
            new_tx_data <= 1'b0;
            frame_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (new_rx_data) begin
`ifdef UART_REG_BRIDGE_CHKSUM_EN
                        chk_r <= rx_data;
`endif
                        if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                            is_wr_r <= (rx_data == CMD_WR);
                            state_r <= ST_ADDR;
                        end else begin
                            resp_r  <= RESP_BADCMD;
                            state_r <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (new_rx_data) begin
                        reg_addr <= rx_data;
`ifdef UART_REG_BRIDGE_CHKSUM_EN
                        chk_r <= chk_accum(chk_r, rx_data);
                        state_r <= is_wr_r ? ST_DATA : ST_CHK;
`else
                        if (is_wr_r) begin
                            state_r <= ST_DATA;
                        end else begin
                            reg_rd  <= 1'b1;
                            state_r <= ST_EXEC;
                        end
`endif
                    end else if (tmo_expire_s) begin
                        frame_err <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (new_rx_data) begin
                        reg_wdata <= rx_data;
`ifdef UART_REG_BRIDGE_CHKSUM_EN
                        chk_r   <= chk_accum(chk_r, rx_data);
                        state_r <= ST_CHK;
`else
                        reg_wr  <= 1'b1;
                        state_r <= ST_EXEC;
`endif
                    end else if (tmo_expire_s) begin
                        frame_err <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
`ifdef UART_REG_BRIDGE_CHKSUM_EN
                ST_CHK: begin
                    if (new_rx_data) begin
                        if (rx_data == chk_r) begin
                            reg_wr  <= is_wr_r;
                            reg_rd  <= !is_wr_r;
                            state_r <= ST_EXEC;
                        end else begin
                            resp_r  <= RESP_BADCHK;
                            state_r <= ST_RESP;
                        end
                    end else if (tmo_expire_s) begin
                        frame_err <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_CHK;
                    end
                end
`endif
                ST_EXEC: begin
                    frame_err <= new_rx_data;
                    if (is_wr_r) begin
                        resp_r  <= RESP_OK;
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    frame_err <= new_rx_data;
                    resp_r    <= reg_rdata;
                    state_r   <= ST_RESP;
                end
                ST_RESP: begin
                    frame_err <= new_rx_data;
                    if (!tx_busy) begin
                        tx_data     <= resp_r;
                        new_tx_data <= 1'b1;
                        state_r     <= ST_RESP_WAIT;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP_WAIT: begin
                    // tx_busy lags new_tx_data by a cycle, so skip one before idling
                    frame_err <= new_rx_data;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed self-checking bench for uart_reg_bridge (timeout shortened to 100
// cycles); checksum-frame vectors are added when UART_REG_BRIDGE_CHKSUM_EN is set.
module tb_uart_reg_bridge;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       new_rx_data = 1'b0;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy = 1'b0;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_err;

    int tests_run = 0;
    int tests_failed = 0;

    int cyc = 0;
    int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
    int wr_cyc = 0, rd_cyc = 0, tx_cyc = 0, err_cyc = 0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00, tx_val = 8'h00;
    int last = 0;
    int b_wr, b_rd, b_tx, b_err;

    uart_reg_bridge #(
        .TIMEOUT_CYCLES (16'd100)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .frame_err   (frame_err)
    );

    always #5 clock = ~clock;

    // Register file model: 8'h22 reads 8'h5C, everything else reads ~addr.
    function automatic logic [7:0] rd_model(input logic [7:0] a);
        return (a == 8'h22) ? 8'h5C : ~a;
    endfunction

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reg_rd) reg_rdata <= rd_model(reg_addr);
    end

    always @(negedge clock) begin
        if (reg_wr) begin
            n_wr <= n_wr + 1; wr_cyc <= cyc; wr_addr <= reg_addr; wr_data <= reg_wdata;
        end
        if (reg_rd) begin
            n_rd <= n_rd + 1; rd_cyc <= cyc; rd_addr <= reg_addr;
        end
        if (new_tx_data) begin
            n_tx <= n_tx + 1; tx_cyc <= cyc; tx_val <= tx_data;
        end
        if (frame_err) begin
            n_err <= n_err + 1; err_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1;
        rx_data = b;
        new_rx_data = 1'b1;
        @(posedge clock);
        #1;
        new_rx_data = 1'b0;
        last = cyc;
    endtask

    // Sends n frame bytes, plus the XOR checksum when the checksum build is active.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int n);
        logic [7:0] x;
        x = b0 ^ b1;
        send_byte(b0);
        send_byte(b1);
        if (n > 2) begin
            x = x ^ b2;
            send_byte(b2);
        end
`ifdef UART_REG_BRIDGE_CHKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic snap();
        b_wr = n_wr; b_rd = n_rd; b_tx = n_tx; b_err = n_err;
    endtask

    initial begin
        wait_cycles(3);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check_eq("rst_strobes", {28'd0, new_tx_data, reg_wr, reg_rd, frame_err}, 32'h0);
        check_eq("rst_addr_wdata", {16'd0, reg_addr, reg_wdata}, 32'h0000);
        reset = 1'b1;
        wait_cycles(2);

        // Write frame
        snap();
        send_frame(8'h57, 8'h10, 8'hA5, 3);
        wait_cycles(10);
        check_eq("wr_count", n_wr - b_wr, 32'd1);
        check_eq("wr_addr", {24'd0, wr_addr}, 32'h10);
        check_eq("wr_data", {24'd0, wr_data}, 32'hA5);
        check_eq("wr_no_rd", n_rd - b_rd, 32'd0);
        check_eq("wr_tx_count", n_tx - b_tx, 32'd1);
        check_eq("wr_tx_data", {24'd0, tx_val}, 32'h4B);
        check_eq("wr_strobe_lat", wr_cyc - last, 32'd0);
        check_eq("wr_tx_lat", tx_cyc - last, 32'd2);

        // Read frame
        snap();
        send_frame(8'h52, 8'h22, 8'h00, 2);
        wait_cycles(10);
        check_eq("rd_count", n_rd - b_rd, 32'd1);
        check_eq("rd_addr", {24'd0, rd_addr}, 32'h22);
        check_eq("rd_no_wr", n_wr - b_wr, 32'd0);
        check_eq("rd_tx_data", {24'd0, tx_val}, 32'h5C);
        check_eq("rd_tx_count", n_tx - b_tx, 32'd1);
        check_eq("rd_tx_lat", tx_cyc - last, 32'd3);

        // Bad command, then a normal read proves the FSM returned to idle
        snap();
        send_byte(8'h00);
        wait_cycles(8);
        check_eq("bad_tx_data", {24'd0, tx_val}, 32'h3F);
        check_eq("bad_no_bus", (n_wr - b_wr) + (n_rd - b_rd), 32'd0);
        check_eq("bad_tx_count", n_tx - b_tx, 32'd1);
        send_frame(8'h52, 8'h41, 8'h00, 2);
        wait_cycles(10);
        check_eq("bad_then_rd", {24'd0, tx_val}, 32'hBE);

        // Inter-byte timeout after W, 01
        snap();
        send_byte(8'h57);
        send_byte(8'h01);
        wait_cycles(90);
        check_eq("tmo_not_early", n_err - b_err, 32'd0);
        wait_cycles(30);
        check_eq("tmo_err_count", n_err - b_err, 32'd1);
        check_eq("tmo_err_window", ((err_cyc - last) >= 95 && (err_cyc - last) <= 105) ? 32'd1 : 32'd0, 32'd1);
        check_eq("tmo_no_bus", (n_wr - b_wr) + (n_rd - b_rd), 32'd0);
        check_eq("tmo_no_tx", n_tx - b_tx, 32'd0);
        snap();
        send_frame(8'h52, 8'h01, 8'h00, 2);
        wait_cycles(10);
        check_eq("tmo_then_rd", {24'd0, tx_val}, 32'hFE);
        check_eq("tmo_then_rd_cnt", n_rd - b_rd, 32'd1);

        // Transmitter busy holds the response; a byte in RESP is dropped
        snap();
        tx_busy = 1'b1;
        send_frame(8'h52, 8'h30, 8'h00, 2);
        wait_cycles(200);
        send_byte(8'h99);
        wait_cycles(300);
        check_eq("busy_no_tx", n_tx - b_tx, 32'd0);
        check_eq("busy_drop_err", n_err - b_err, 32'd1);
        tx_busy = 1'b0;
        wait_cycles(10);
        check_eq("busy_tx_count", n_tx - b_tx, 32'd1);
        check_eq("busy_tx_data", {24'd0, tx_val}, 32'hCF);

        // Reset mid-frame abandons the frame and clears outputs
        snap();
        send_byte(8'h57);
        send_byte(8'h10);
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(3);
        check_eq("mid_rst_outputs", {tx_data, reg_addr, reg_wdata, 4'd0, new_tx_data, reg_wr, reg_rd, frame_err}, 32'h0);
        check_eq("mid_rst_no_wr", n_wr - b_wr, 32'd0);
        reset = 1'b1;
        wait_cycles(2);
        send_frame(8'h52, 8'h22, 8'h00, 2);
        wait_cycles(10);
        check_eq("post_rst_rd", {24'd0, tx_val}, 32'h5C);

`ifdef UART_REG_BRIDGE_CHKSUM_EN
        snap();
        send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5); send_byte(8'hE2);
        wait_cycles(10);
        check_eq("chk_ok_tx", {24'd0, tx_val}, 32'h4B);
        check_eq("chk_ok_wr", n_wr - b_wr, 32'd1);
        snap();
        send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5); send_byte(8'h00);
        wait_cycles(10);
        check_eq("chk_bad_tx", {24'd0, tx_val}, 32'h21);
        check_eq("chk_bad_no_wr", n_wr - b_wr, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
